// File: rtl/bnn_serial_score_ctrl.sv
// ============================================================================
// bnn_serial_score_ctrl: serial XNOR/popcount class scoring with serial argmax
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bnn_serial_score_ctrl #(
  parameter int                                HIDDEN_CNT = 40,
  parameter int                                CLASS_CNT  = 6,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0]   WEIGHTS    = '0,
  parameter int                                SUM_BITS   = $clog2(HIDDEN_CNT + 1),
  parameter int                                IDX_BITS   = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [HIDDEN_CNT-1:0] hidden_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_BITS-1:0]   prediction,
  output logic [SUM_BITS-1:0]   score_max,
  output logic                  busy
);

  localparam int BIT_BITS = (HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1;
  localparam logic [BIT_BITS-1:0] c_last_bit   = BIT_BITS'(HIDDEN_CNT - 1);
  localparam logic [IDX_BITS-1:0] c_last_class = IDX_BITS'(CLASS_CNT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_ARGMAX = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [HIDDEN_CNT-1:0] hid_q, hid_d;
  logic [SUM_BITS-1:0]   score_q [CLASS_CNT];
  logic [SUM_BITS-1:0]   score_d [CLASS_CNT];
  logic [BIT_BITS-1:0]   bit_idx_q, bit_idx_d;
  logic [IDX_BITS-1:0]   class_idx_q, class_idx_d;
  logic [SUM_BITS-1:0]   best_q, best_d;
  logic [IDX_BITS-1:0]   best_idx_q, best_idx_d;
  logic [IDX_BITS-1:0]   prediction_q, prediction_d;
  logic [SUM_BITS-1:0]   score_max_q, score_max_d;
  logic                  out_valid_q, out_valid_d;

  logic [CLASS_CNT-1:0]  w_match;
  logic [SUM_BITS-1:0]   w_cur_score;
  logic                  w_take;
  logic [SUM_BITS-1:0]   w_best;
  logic [IDX_BITS-1:0]   w_best_idx;

  // One weight row per class; every class compares against the same hidden bit.
  for (genvar c = 0; c < CLASS_CNT; c++) begin : g_match
    localparam logic [HIDDEN_CNT-1:0] c_row = WEIGHTS[c*HIDDEN_CNT +: HIDDEN_CNT];
    assign w_match[c] = ~(hid_q[bit_idx_q] ^ c_row[bit_idx_q]);
  end

  // Strict compare keeps the earliest class on ties; class 0 always seeds.
  assign w_cur_score = score_q[class_idx_q];
  assign w_take      = (class_idx_q == '0) || (w_cur_score > best_q);
  assign w_best      = w_take ? w_cur_score : best_q;
  assign w_best_idx  = w_take ? class_idx_q : best_idx_q;

  always_comb begin
    state_d      = state_q;
    hid_d        = hid_q;
    score_d      = score_q;
    bit_idx_d    = bit_idx_q;
    class_idx_d  = class_idx_q;
    best_d       = best_q;
    best_idx_d   = best_idx_q;
    prediction_d = prediction_q;
    score_max_d  = score_max_q;
    out_valid_d  = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          hid_d     = hidden_in;
          bit_idx_d = '0;
          for (int c = 0; c < CLASS_CNT; c++) begin
            score_d[c] = '0;
          end
          state_d = S_ACCUM;
        end
      end

      S_ACCUM: begin
        for (int c = 0; c < CLASS_CNT; c++) begin
          score_d[c] = score_q[c] + SUM_BITS'(w_match[c]);
        end
        if (bit_idx_q == c_last_bit) begin
          bit_idx_d   = '0;
          class_idx_d = '0;
          best_d      = '0;
          best_idx_d  = '0;
          state_d     = S_ARGMAX;
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end

      S_ARGMAX: begin
        best_d     = w_best;
        best_idx_d = w_best_idx;
        if (class_idx_q == c_last_class) begin
          class_idx_d  = '0;
          prediction_d = w_best_idx;
          score_max_d  = w_best;
          out_valid_d  = 1'b1;
          state_d      = S_DONE;
        end else begin
          class_idx_d = class_idx_q + 1'b1;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hid_q        <= '0;
      score_q      <= '{default: '0};
      bit_idx_q    <= '0;
      class_idx_q  <= '0;
      best_q       <= '0;
      best_idx_q   <= '0;
      prediction_q <= '0;
      score_max_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hid_q        <= hid_d;
      score_q      <= score_d;
      bit_idx_q    <= bit_idx_d;
      class_idx_q  <= class_idx_d;
      best_q       <= best_d;
      best_idx_q   <= best_idx_d;
      prediction_q <= prediction_d;
      score_max_q  <= score_max_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE) && !rst;
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = out_valid_q;
  assign prediction = prediction_q;
  assign score_max  = score_max_q;

endmodule

`default_nettype wire

// File: tb/tb_bnn_serial_score_ctrl.sv
// Bench for bnn_serial_score_ctrl: four instances with different weight sets share
// one stimulus stream and are checked every cycle against a popcount/argmax model.
`timescale 1ns/1ps
`default_nettype none

module tb_bnn_serial_score_ctrl;

  localparam int H   = 40;
  localparam int C   = 6;
  localparam int NI  = 4;
  localparam int LAT = H + C;

  typedef logic [C*H-1:0] w_t;

  localparam w_t W0 = {120'h0, {40{1'b1}}, 80'h0};
  localparam w_t W1 = '0;
  localparam w_t W2 = {240{1'b1}};
  localparam w_t W3 = {60'h9E3779B97F4A7C1, 60'h3C6EF372FE94F82,
                       60'hDAA66D2C7DDF743, 60'h7F4A7C15F39CC06};
  localparam w_t WTAB [NI] = '{W0, W1, W2, W3};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [H-1:0] hidden_in = '0;

  logic       ir [NI];
  logic       ov [NI];
  logic       bz [NI];
  logic [2:0] pr [NI];
  logic [5:0] sm [NI];

  for (genvar i = 0; i < NI; i++) begin : g_dut
    bnn_serial_score_ctrl #(
      .HIDDEN_CNT (H),
      .CLASS_CNT  (C),
      .WEIGHTS    (WTAB[i])
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (ir[i]),
      .hidden_in  (hidden_in),
      .out_valid  (ov[i]),
      .out_ready  (out_ready),
      .prediction (pr[i]),
      .score_max  (sm[i]),
      .busy       (bz[i])
    );
  end

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int or_mode  = 1;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0d expected=%0d at cycle %0d", name, inst, act, exp, cyc);
    end
  endtask

  // Golden model: count XNOR matches per class, keep first class with highest count.
  function automatic void golden(input w_t w, input logic [H-1:0] h,
                                 output int pred, output int score);
    int best = -1;
    pred = 0;
    for (int c = 0; c < C; c++) begin
      int s = 0;
      for (int j = 0; j < H; j++) if (h[j] == w[c*H+j]) s++;
      if (s > best) begin
        best = s;
        pred = c;
      end
    end
    score = best;
  endfunction

  bit           m_busy = 1'b0;
  bit           m_valid = 1'b0;
  int           m_cnt = 0;
  logic [H-1:0] m_hid = '0;
  int           m_pred  [NI];
  int           m_score [NI];
  int           n_acc = 0;
  int           n_res_model = 0;
  int           n_res_dut = 0;

  // Cycle-level expectation: a vector accepted in idle yields its result LAT edges later.
  initial begin
    foreach (m_pred[i]) begin
      m_pred[i]  = 0;
      m_score[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_busy  = 1'b0;
        m_valid = 1'b0;
        foreach (m_pred[i]) begin
          m_pred[i]  = 0;
          m_score[i] = 0;
        end
      end else if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1'b1;
          m_cnt  = 0;
          m_hid  = hidden_in;
          n_acc++;
        end
      end else if (m_valid) begin
        if (out_ready) begin
          m_valid = 1'b0;
          m_busy  = 1'b0;
          n_res_model++;
        end
      end else begin
        m_cnt++;
        if (m_cnt == LAT) begin
          m_valid = 1'b1;
          for (int i = 0; i < NI; i++) golden(WTAB[i], m_hid, m_pred[i], m_score[i]);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < NI; i++) begin
          chk("in_ready",   i, 32'(ir[i]), 32'(!m_busy && !rst));
          chk("busy",       i, 32'(bz[i]), 32'(m_busy));
          chk("out_valid",  i, 32'(ov[i]), 32'(m_valid));
          chk("prediction", i, 32'(pr[i]), 32'(m_pred[i]));
          chk("score_max",  i, 32'(sm[i]), 32'(m_score[i]));
        end
        if (ov[3] && out_ready) n_res_dut++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send(input logic [H-1:0] h);
    int n = 0;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    hidden_in = h;
    @(negedge clk);
    while (!ir[0] && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!ir[0]) chk("send_timeout", -1, 32'(ir[0]), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic wait_result(input bit toggle, output int lat);
    int n = 0;
    @(negedge clk);
    while (!ov[0] && n < 300) begin
      n++;
      if (toggle) hidden_in = ~hidden_in;
      @(negedge clk);
    end
    chk("result_timeout", -1, 32'(ov[0]), 32'd1);
    lat = cyc - acc_cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bz[0] && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("idle_timeout", -1, 32'(bz[0]), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int prev_acc;
    int seen;
    logic [2:0] hold_p;
    logic [5:0] hold_s;

    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 0, 32'(ov[0]), 32'd0);
    chk("reset_prediction", 0, 32'(pr[0]), 32'd0);
    chk("reset_score_max", 0, 32'(sm[0]), 32'd0);
    chk("reset_in_ready", 0, 32'(ir[0]), 32'd1);

    // Only class 2 matches an all-ones vector under W0.
    send({H{1'b1}});
    wait_result(1'b0, lat);
    chk("t1_latency", -1, 32'(lat), 32'd46);
    chk("t1_pred", 0, 32'(pr[0]), 32'd2);
    chk("t1_score", 0, 32'(sm[0]), 32'd40);
    chk("t1_model_pred", 0, 32'(m_pred[0]), 32'd2);
    chk("t1_pred", 1, 32'(pr[1]), 32'd0);
    chk("t1_score", 1, 32'(sm[1]), 32'd0);
    chk("t1_score", 2, 32'(sm[2]), 32'd40);

    // Back-to-back with out_ready high: full tie for zero weights.
    prev_acc = acc_cyc;
    send('0);
    chk("throughput", -1, 32'(acc_cyc - prev_acc), 32'd48);
    wait_result(1'b0, lat);
    chk("t2_pred", 1, 32'(pr[1]), 32'd0);
    chk("t2_score", 1, 32'(sm[1]), 32'd40);
    chk("t2_model_score", 1, 32'(m_score[1]), 32'd40);
    chk("t2_pred", 0, 32'(pr[0]), 32'd0);
    chk("t2_score", 0, 32'(sm[0]), 32'd40);

    // Result backpressure with a competing input vector.
    send(40'h123456789A);
    or_mode = 0;
    wait_result(1'b0, lat);
    hold_p    = pr[3];
    hold_s    = sm[3];
    in_valid  = 1'b1;
    hidden_in = 40'hF0F0F0F0F0;
    repeat (10) begin
      @(negedge clk);
      chk("bp_pred_stable", 3, 32'(pr[3]), 32'(hold_p));
      chk("bp_score_stable", 3, 32'(sm[3]), 32'(hold_s));
      chk("bp_in_ready", 3, 32'(ir[3]), 32'd0);
    end
    or_mode = 1;
    send(40'hF0F0F0F0F0);
    wait_result(1'b0, lat);
    chk("t3_pred", 2, 32'(pr[2]), 32'd0);
    chk("t3_score", 2, 32'(sm[2]), 32'd20);
    chk("t3_score", 1, 32'(sm[1]), 32'd20);

    // Reset sampled on the 20th accumulation edge aborts the vector.
    send(40'hAAAAAAAAAA);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t4_in_ready", 0, 32'(ir[0]), 32'd1);
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    chk("t4_no_result", 0, 32'(seen), 32'd0);
    send(40'h00000000FF);
    wait_result(1'b0, lat);
    chk("t4_pred", 2, 32'(pr[2]), 32'd0);
    chk("t4_score", 2, 32'(sm[2]), 32'd8);

    // Input toggling after capture must not disturb the result.
    send(40'h0123456789);
    wait_result(1'b1, lat);
    chk("t5_score", 2, 32'(sm[2]), 32'd15);
    chk("t5_score", 1, 32'(sm[1]), 32'd25);
    chk("t5_pred", 1, 32'(pr[1]), 32'd0);

    or_mode = 2;
    for (int t = 0; t < 1000; t++) begin
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) @(posedge clk);
      send(r[H-1:0]);
    end
    or_mode = 1;
    wait_idle();
    chk("results_vs_model", -1, 32'(n_res_dut), 32'(n_res_model));
    chk("accept_count", -1, 32'(n_acc), 32'd1007);
    chk("result_count", -1, 32'(n_res_dut), 32'd1006);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
